// File: rtl/tc0260dar.sv
// Palette lookup and colour DAC stage: the video index is looked up in a word-wide palette RAM,
// the RAM is shared with a 68000 byte-lane bus, and the result is blanked and sent out as 8-bit RGB.
module tc0260dar #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned RGB_FORMAT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce_pixel,
  input  logic [ADDR_WIDTH-1:0] VA,
  input  logic [15:0]           Din,
  output logic [15:0]           Dout,
  input  logic                  UDSn,
  input  logic                  LDSn,
  input  logic                  RW,
  input  logic                  DACCSn,
  output logic                  DACKn,
  input  logic [13:0]           IM,
  input  logic                  HBLn,
  input  logic                  VBLn,
  output logic [7:0]            R,
  output logic [7:0]            G,
  output logic [7:0]            B,
  output logic                  HBLOn,
  output logic                  VBLOn
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RDATA, ACK, WAITCS} cpu_state_t;

  logic [15:0]           ram [DEPTH];
  logic [15:0]           ram_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;

  logic                  ce_d;
  logic                  hb_d;
  logic                  vb_d;
  logic [15:0]           pix;
  logic [4:0]            r5, g5, b5;

  cpu_state_t            state, state_nx;
  logic                  prev_cs;
  logic                  pending;
  logic                  dtack_n;
  logic                  issue_wr;
  logic                  clr_pending;
  logic                  load_dout;
  logic                  set_ack;

  logic                  unused_bits;
  assign unused_bits = ^{IM[13:ADDR_WIDTH], pix[15], pix[0]};

  function automatic logic [7:0] widen(input logic [4:0] c5);
    return {c5, c5[4:2]};
  endfunction

  // Video owns every ce_pixel clock; the CPU gets the rest.
  assign ram_addr = ce_pixel ? IM[ADDR_WIDTH-1:0] : VA;
  assign ram_we   = issue_wr & ~reset;

  always_ff @(posedge clk) begin
    if (ram_we && !UDSn) ram[ram_addr][15:8] <= Din[15:8];
    if (ram_we && !LDSn) ram[ram_addr][7:0]  <= Din[7:0];
    ram_q <= ram[ram_addr];
  end

  always_comb begin
    if (RGB_FORMAT == 0) begin
      r5 = {pix[15:12], pix[3]};
      g5 = {pix[11:8],  pix[2]};
      b5 = {pix[7:4],   pix[1]};
    end else begin
      r5 = pix[4:0];
      g5 = pix[9:5];
      b5 = pix[14:10];
    end
  end

  // pix holds the colour word read in the last video slot until the next pixel edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_d  <= 1'b0;
      hb_d  <= 1'b0;
      vb_d  <= 1'b0;
      pix   <= '0;
      R     <= '0;
      G     <= '0;
      B     <= '0;
      HBLOn <= 1'b0;
      VBLOn <= 1'b0;
    end else begin
      ce_d <= ce_pixel;
      if (ce_d) pix <= ram_q;
      if (ce_pixel) begin
        hb_d  <= HBLn;
        vb_d  <= VBLn;
        HBLOn <= hb_d;
        VBLOn <= vb_d;
        if (hb_d && vb_d) begin
          R <= widen(r5);
          G <= widen(g5);
          B <= widen(b5);
        end else begin
          R <= '0;
          G <= '0;
          B <= '0;
        end
      end
    end
  end

  assign DACKn = DACCSn ? 1'b0 : dtack_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prev_cs <= 1'b1;
      pending <= 1'b0;
      dtack_n <= 1'b1;
      Dout    <= '0;
    end else begin
      state   <= state_nx;
      prev_cs <= DACCSn;
      if (prev_cs && !DACCSn) pending <= 1'b1;
      else if (clr_pending)   pending <= 1'b0;
      if (DACCSn)       dtack_n <= 1'b1;
      else if (set_ack) dtack_n <= 1'b0;
      if (load_dout) Dout <= ram_q;
    end
  end

  // A pending access waits out any video slot; the slot after a read issue is always free.
  always_comb begin
    state_nx    = state;
    issue_wr    = 1'b0;
    clr_pending = 1'b0;
    load_dout   = 1'b0;
    set_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (pending && !ce_pixel) begin
          clr_pending = 1'b1;
          if (RW) begin
            state_nx = RDATA;
          end else begin
            issue_wr = 1'b1;
            state_nx = ACK;
          end
        end
      end
      RDATA: begin
        load_dout = 1'b1;
        state_nx  = ACK;
      end
      ACK: begin
        set_ack  = 1'b1;
        state_nx = WAITCS;
      end
      WAITCS: begin
        if (DACCSn) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tc0260dar.sv
// Bench for tc0260dar: both colour formats side by side, a table of palette vectors,
// hand-built bus/reset corner sequences and a randomized phase against a palette model.
module tb_tc0260dar;

  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          reset, ce_pixel, UDSn, LDSn, RW, DACCSn, HBLn, VBLn;
  logic [AW-1:0] VA;
  logic [15:0]   Din;
  logic [13:0]   IM;
  logic [15:0]   dout0, dout1;
  logic          dackn0, dackn1;
  logic [7:0]    r0, g0, b0, r1, g1, b1;
  logic          hblo0, vblo0, hblo1, vblo1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_m [DEPTH];
  bit          mem_v [DEPTH];

  tc0260dar #(.ADDR_WIDTH(AW), .RGB_FORMAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .VA(VA), .Din(Din), .Dout(dout0),
    .UDSn(UDSn), .LDSn(LDSn), .RW(RW), .DACCSn(DACCSn), .DACKn(dackn0), .IM(IM),
    .HBLn(HBLn), .VBLn(VBLn), .R(r0), .G(g0), .B(b0), .HBLOn(hblo0), .VBLOn(vblo0));

  tc0260dar #(.ADDR_WIDTH(AW), .RGB_FORMAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .VA(VA), .Din(Din), .Dout(dout1),
    .UDSn(UDSn), .LDSn(LDSn), .RW(RW), .DACCSn(DACCSn), .DACKn(dackn1), .IM(IM),
    .HBLn(HBLn), .VBLn(VBLn), .R(r1), .G(g1), .B(b1), .HBLOn(hblo1), .VBLOn(vblo1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] widen(input int c5);
    return 8'(c5 * 8 + c5 / 4);
  endfunction

  // Colour word to 24-bit RGB, straight from the field layout of each format.
  function automatic logic [23:0] to_rgb(input logic [15:0] w, input bit fmt1);
    int v, r, g, b;
    v = int'(w);
    if (fmt1) begin
      r = v % 32;
      g = (v / 32) % 32;
      b = (v / 1024) % 32;
    end else begin
      r = ((v / 4096) % 16) * 2 + (v / 8) % 2;
      g = ((v / 256) % 16) * 2 + (v / 4) % 2;
      b = ((v / 16) % 16) * 2 + (v / 2) % 2;
    end
    return {widen(r), widen(g), widen(b)};
  endfunction

  // One clock; ce_pixel alternates so it is never high on consecutive clocks.
  task automatic cyc();
    @(posedge clk);
    #1;
    ce_pixel = ~ce_pixel;
  endtask

  // Video reference: what is sampled on one pixel edge appears on the next pixel edge.
  logic [15:0] pend_w;
  logic        pend_ok, pend_hb, pend_vb;
  logic [23:0] e_rgb0, e_rgb1;
  logic        e_hb, e_vb, e_ok;

  always @(posedge clk) begin
    if (reset) begin
      pend_w = '0; pend_ok = 1'b0; pend_hb = 1'b0; pend_vb = 1'b0;
      e_rgb0 = '0; e_rgb1 = '0; e_hb = 1'b0; e_vb = 1'b0; e_ok = 1'b1;
    end else if (ce_pixel) begin
      e_hb = pend_hb;
      e_vb = pend_vb;
      if (pend_hb && pend_vb) begin
        e_ok   = pend_ok;
        e_rgb0 = to_rgb(pend_w, 1'b0);
        e_rgb1 = to_rgb(pend_w, 1'b1);
      end else begin
        e_ok = 1'b1; e_rgb0 = '0; e_rgb1 = '0;
      end
      pend_w  = mem_m[int'(IM) % DEPTH];
      pend_ok = mem_v[int'(IM) % DEPTH];
      pend_hb = HBLn;
      pend_vb = VBLn;
    end
    #1;
    check("video_blank_f0", 32'({hblo0, vblo0}), 32'({e_hb, e_vb}));
    check("video_blank_f1", 32'({hblo1, vblo1}), 32'({e_hb, e_vb}));
    if (e_ok) begin
      check("video_rgb_f0", 32'({r0, g0, b0}), 32'(e_rgb0));
      check("video_rgb_f1", 32'({r1, g1, b1}), 32'(e_rgb1));
    end
  end

  // One bus cycle. The access issues on the first non-pixel clock after the clock that
  // sees the select edge; a write acks one clock after issue, a read two.
  task automatic cpu_access(input logic rw, input logic [AW-1:0] va, input logic [15:0] din,
                            input logic uds, input logic lds, input logic align_ce,
                            output logic [15:0] rd);
    int lat, k, exp_lat;
    logic ce_now;
    while (ce_pixel != align_ce) cyc();
    VA = va; Din = din; RW = rw; UDSn = uds; LDSn = lds; DACCSn = 1'b0;
    #1;
    check("dack_high_at_cs_fall", 32'({dackn0, dackn1}), 32'(2'b11));
    lat = 0;
    k = 0;
    for (int e = 1; e <= 8; e++) begin
      ce_now = ce_pixel;
      cyc();
      if (k == 0 && e >= 2 && !ce_now) begin
        k = e;
        if (!rw) begin
          if (!uds) mem_m[va][15:8] = din[15:8];
          if (!lds) mem_m[va][7:0]  = din[7:0];
          mem_v[va] = mem_v[va] | (!uds && !lds);
        end
      end
      if (!dackn0 && !dackn1) begin
        lat = e;
        break;
      end
    end
    exp_lat = rw ? k + 2 : k + 1;
    check(rw ? "read_dack_latency" : "write_dack_latency", 32'(lat), 32'(exp_lat));
    rd = dout0;
    if (rw && mem_v[va]) begin
      check("read_data_f0", 32'(dout0), 32'(mem_m[va]));
      check("read_data_f1", 32'(dout1), 32'(mem_m[va]));
    end
    DACCSn = 1'b1;
    cyc();
    check("dack_with_cs_high", 32'({dackn0, dackn1}), 32'(2'b00));
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [13:0]   im;
    logic [15:0]   word;
    logic          hb;
    logic          vb;
    logic [23:0]   rgb0;
    logic [23:0]   rgb1;
  } vec_t;

  vec_t tv [8];

  initial begin
    logic [15:0] rd;

    tv[0] = '{13'h0010, 14'h0010, 16'hF0FA, 1'b1, 1'b1, 24'hFF00FF, 24'hD639E7};
    tv[1] = '{13'h0005, 14'h0005, 16'h7C1F, 1'b1, 1'b1, 24'h7BCE18, 24'hFF00FF};
    tv[2] = '{13'h0006, 14'h0006, 16'h03E0, 1'b1, 1'b1, 24'h0031E7, 24'h00FF00};
    tv[3] = '{13'h1FFF, 14'h3FFF, 16'hFFFE, 1'b1, 1'b1, 24'hFFFFFF, 24'hF7FFFF};
    tv[4] = '{13'h0000, 14'h2000, 16'h0000, 1'b1, 1'b1, 24'h000000, 24'h000000};
    tv[5] = '{13'h0011, 14'h0011, 16'hFFFE, 1'b0, 1'b1, 24'h000000, 24'h000000};
    tv[6] = '{13'h0012, 14'h0012, 16'h7C1F, 1'b1, 1'b0, 24'h000000, 24'h000000};
    tv[7] = '{13'h0013, 14'h2013, 16'h8421, 1'b1, 1'b1, 24'h844221, 24'h080808};

    reset = 1'b1; ce_pixel = 1'b0; IM = '0; HBLn = 1'b1; VBLn = 1'b1;
    DACCSn = 1'b1; RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1; VA = '0; Din = '0;
    repeat (4) cyc();
    check("reset_dout", 32'({dout0, dout1}), 32'h0);
    check("reset_rgb", 32'({r0, g0, b0}), 32'h0);
    check("reset_blank", 32'({hblo0, vblo0, hblo1, vblo1}), 32'h0);
    reset = 1'b0;
    while (ce_pixel != 1'b1) cyc();
    cyc();
    check("first_ce_after_reset", 32'({hblo0, vblo0, r0, g0, b0}), 32'h0);
    while (ce_pixel != 1'b1) cyc();
    cyc();
    check("second_ce_after_reset", 32'({hblo0, vblo0}), 32'(2'b11));

    for (int i = 0; i < 8; i++)
      cpu_access(1'b0, tv[i].addr, tv[i].word, 1'b0, 1'b0, 1'(i % 2), rd);

    for (int i = 0; i < 8; i++) begin
      while (ce_pixel != 1'b1) cyc();
      IM = tv[i].im; HBLn = tv[i].hb; VBLn = tv[i].vb;
      cyc();
      IM = 14'h0010; HBLn = 1'b1; VBLn = 1'b1;
      while (ce_pixel != 1'b1) cyc();
      cyc();
      check($sformatf("vec%0d_rgb_f0", i), 32'({r0, g0, b0}), 32'(tv[i].rgb0));
      check($sformatf("vec%0d_rgb_f1", i), 32'({r1, g1, b1}), 32'(tv[i].rgb1));
      check($sformatf("vec%0d_blank", i), 32'({hblo0, vblo0}), 32'({tv[i].hb, tv[i].vb}));
    end

    // Byte lanes: upper only, lower only, then neither.
    cpu_access(1'b0, 13'h0007, 16'h1234, 1'b0, 1'b0, 1'b1, rd);
    cpu_access(1'b0, 13'h0007, 16'hAB00, 1'b0, 1'b1, 1'b1, rd);
    cpu_access(1'b1, 13'h0007, 16'h0000, 1'b1, 1'b1, 1'b1, rd);
    check("byte_write_upper", 32'(rd), 32'h0000AB34);
    cpu_access(1'b0, 13'h0007, 16'hFFCD, 1'b1, 1'b0, 1'b0, rd);
    cpu_access(1'b0, 13'h0007, 16'hFFFF, 1'b1, 1'b1, 1'b0, rd);
    cpu_access(1'b1, 13'h0007, 16'h0000, 1'b1, 1'b1, 1'b0, rd);
    check("byte_write_lower_then_none", 32'(rd), 32'h0000ABCD);

    // Video read of a just-written address sees the new word.
    IM = 14'h0005; HBLn = 1'b1; VBLn = 1'b1;
    cpu_access(1'b0, 13'h0005, 16'h03E0, 1'b0, 1'b0, 1'b1, rd);
    while (ce_pixel != 1'b1) cyc();
    cyc();
    while (ce_pixel != 1'b1) cyc();
    cyc();
    check("write_then_video_f1", 32'({r1, g1, b1}), 32'h0000FF00);

    // Reset landing on the issue clock cancels the write.
    cpu_access(1'b0, 13'h0030, 16'h5555, 1'b0, 1'b0, 1'b1, rd);
    while (ce_pixel != 1'b1) cyc();
    VA = 13'h0030; Din = 16'hAAAA; RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; DACCSn = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    check("dack_in_reset_cs_low", 32'({dackn0, dackn1}), 32'(2'b11));
    check("dout_in_reset", 32'(dout0), 32'h0);
    DACCSn = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    cpu_access(1'b1, 13'h0030, 16'h0000, 1'b1, 1'b1, 1'b0, rd);
    check("reset_aborted_write", 32'(rd), 32'h00005555);

    // Randomized traffic over a small palette window.
    for (int a = 32; a < 48; a++)
      cpu_access(1'b0, AW'(a), 16'($urandom), 1'b0, 1'b0, 1'($urandom % 2), rd);
    for (int n = 0; n < 60; n++) begin
      IM   = 14'($urandom_range(32, 47)) | (($urandom % 2) != 0 ? 14'h2000 : 14'h0000);
      HBLn = ($urandom % 4) != 0;
      VBLn = ($urandom % 4) != 0;
      cpu_access(1'($urandom % 2), AW'($urandom_range(32, 47)), 16'($urandom),
                 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), rd);
      repeat ($urandom_range(1, 4)) begin
        IM   = 14'($urandom_range(32, 47));
        HBLn = ($urandom % 4) != 0;
        VBLn = ($urandom % 4) != 0;
        cyc();
      end
    end

    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
